logic_trigger_sequencer: RTL and testbench

Parametrised trigger sequencer for the logic-analyzer capture path, running in the RAM 2x clock domain. It sequences reset, pre-trigger fill, armed, post-trigger fill, flush and download-wait for NUM_CHANNELS capture ports. Unlike its predecessor, it evaluates a real mask/value/edge trigger on a sample stream, supports runtime pre/post depths, single or continuous re-arm, force trigger, and abort. Per-port clock-domain crossing stays outside this block.

---
 rtl/logic_trig_pkg.sv | 28 ++
 rtl/logic_trigger_sequencer_match.sv | 48 ++++
 rtl/logic_trigger_sequencer.sv | 199 +++++++++++++++++++
 tb/tb_logic_trigger_sequencer.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/logic_trig_pkg.sv
// Shared types and constants for the logic-analyzer trigger sequencer.
// State encodings are exported both as an enum and as plain logic constants.
package logic_trig_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    TS_IDLE      = 3'd0,
    TS_RESET     = 3'd1,
    TS_PRE_TRIG  = 3'd2,
    TS_ARMED     = 3'd3,
    TS_POST_TRIG = 3'd4,
    TS_DONE      = 3'd5,
    TS_CLEAR     = 3'd6
  } trig_state_t;

  localparam logic [STATE_W-1:0] ST_IDLE      = TS_IDLE;
  localparam logic [STATE_W-1:0] ST_RESET     = TS_RESET;
  localparam logic [STATE_W-1:0] ST_PRE_TRIG  = TS_PRE_TRIG;
  localparam logic [STATE_W-1:0] ST_ARMED     = TS_ARMED;
  localparam logic [STATE_W-1:0] ST_POST_TRIG = TS_POST_TRIG;
  localparam logic [STATE_W-1:0] ST_DONE      = TS_DONE;
  localparam logic [STATE_W-1:0] ST_CLEAR     = TS_CLEAR;

  localparam int DEFAULT_PRE_DEPTH  = 4;
  localparam int DEFAULT_POST_DEPTH = 8;

endpackage

// File: rtl/logic_trigger_sequencer_match.sv
// Mask/value/edge trigger comparator with latched configuration.
// fire is combinational from the current sample so the FSM reacts on the same edge.
module logic_trig_match #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic                  clear_prev,
  input  logic [DATA_WIDTH-1:0] mask,
  input  logic [DATA_WIDTH-1:0] value,
  input  logic                  edge_mode,
  input  logic                  sample_valid,
  input  logic [DATA_WIDTH-1:0] sample_data,
  output logic                  fire
);

  logic [DATA_WIDTH-1:0] mask_q;
  logic [DATA_WIDTH-1:0] value_q;
  logic                  edge_q;
  logic                  prev_hit_q;
  logic                  hit;

  assign hit  = sample_valid && (((sample_data ^ value_q) & mask_q) == '0);
  assign fire = hit && (!edge_q || !prev_hit_q);

  // prev_hit only tracks qualified samples so idle gaps do not re-open an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mask_q     <= '0;
      value_q    <= '0;
      edge_q     <= 1'b0;
      prev_hit_q <= 1'b0;
    end else begin
      if (load) begin
        mask_q  <= mask;
        value_q <= value;
        edge_q  <= edge_mode;
      end
      if (clear_prev) begin
        prev_hit_q <= 1'b0;
      end else if (sample_valid) begin
        prev_hit_q <= hit;
      end
    end
  end

endmodule

// File: rtl/logic_trigger_sequencer.sv
// Trigger sequencer for the LA capture path (RAM 2x clock domain).
// Optional AUTO-mode timeout enabled by defining LOGIC_TRIG_AUTO_EN.
module logic_trigger_sequencer
  import logic_trig_pkg::*;
#(
  parameter int NUM_CHANNELS  = 2,
  parameter int DATA_WIDTH    = 32,
  parameter int COUNT_WIDTH   = 32,
  parameter int RESET_CYCLES  = 32,
  parameter int SETTLE_CYCLES = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    arm_req,
  input  logic                    mode_continuous,
  input  logic                    force_trig,
  input  logic [NUM_CHANNELS-1:0] ch_en,
  input  logic [COUNT_WIDTH-1:0]  pre_depth,
  input  logic [COUNT_WIDTH-1:0]  post_depth,
  input  logic [DATA_WIDTH-1:0]   trig_mask,
  input  logic [DATA_WIDTH-1:0]   trig_value,
  input  logic                    trig_edge,
  input  logic                    sample_valid,
  input  logic [DATA_WIDTH-1:0]   sample_data,
  input  logic                    download_done,
`ifdef LOGIC_TRIG_AUTO_EN
  input  logic [COUNT_WIDTH-1:0]  auto_timeout,
`endif
  output logic                    trig_rst,
  output logic [NUM_CHANNELS-1:0] capture_en,
  output logic [NUM_CHANNELS-1:0] capture_flush,
  output logic                    triggered,
  output logic                    aborted,
  output logic [2:0]              state
);

  localparam logic [COUNT_WIDTH-1:0] RST_LAST    = COUNT_WIDTH'(RESET_CYCLES - 1);
  localparam logic [COUNT_WIDTH-1:0] SETTLE_LAST = COUNT_WIDTH'(RESET_CYCLES + SETTLE_CYCLES - 1);

  logic [STATE_W-1:0]      state_q;
  logic [COUNT_WIDTH-1:0]  count_q;
  logic [COUNT_WIDTH-1:0]  count_inc;
  logic [NUM_CHANNELS-1:0] ch_en_q;
  logic [COUNT_WIDTH-1:0]  pre_q;
  logic [COUNT_WIDTH-1:0]  post_q;
  logic                    load_cfg;
  logic                    rearm;
  logic                    abort_now;
  logic                    enter_armed;
  logic                    match_fire;
  logic                    auto_fire;

  assign state       = state_q;
  assign count_inc   = (count_q == '1) ? count_q : count_q + 1'b1;
  assign rearm       = (state_q == ST_DONE) && download_done && mode_continuous && arm_req;
  assign load_cfg    = ((state_q == ST_IDLE) && arm_req) || rearm;
  assign abort_now   = !arm_req && ((state_q == ST_RESET) || (state_q == ST_PRE_TRIG) ||
                                    (state_q == ST_ARMED));
  assign enter_armed = (state_q == ST_PRE_TRIG) && arm_req && (count_q == pre_q);

`ifdef LOGIC_TRIG_AUTO_EN
  logic [COUNT_WIDTH-1:0] auto_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      auto_q <= '0;
    end else if (load_cfg) begin
      auto_q <= auto_timeout;
    end
  end

  assign auto_fire = (auto_q != '0) && (count_q == auto_q);
`else
  assign auto_fire = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ch_en_q <= '0;
      pre_q   <= '0;
      post_q  <= '0;
    end else if (load_cfg) begin
      ch_en_q <= ch_en;
      pre_q   <= pre_depth;
      post_q  <= post_depth;
    end
  end

  logic_trig_match #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_match (
    .clk         (clk),
    .rst_n       (rst_n),
    .load        (load_cfg),
    .clear_prev  (enter_armed),
    .mask        (trig_mask),
    .value       (trig_value),
    .edge_mode   (trig_edge),
    .sample_valid(sample_valid),
    .sample_data (sample_data),
    .fire        (match_fire)
  );

  // Abort takes precedence over everything else in the pre-trigger states.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      count_q       <= '0;
      trig_rst      <= 1'b0;
      capture_en    <= '0;
      capture_flush <= '0;
      triggered     <= 1'b0;
      aborted       <= 1'b0;
    end else begin
      capture_flush <= '0;
      aborted       <= 1'b0;
      if (abort_now) begin
        trig_rst   <= 1'b0;
        capture_en <= '0;
        aborted    <= 1'b1;
        count_q    <= '0;
        state_q    <= ST_IDLE;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (arm_req) begin
              trig_rst <= 1'b1;
              count_q  <= '0;
              state_q  <= ST_RESET;
            end
          end
          ST_RESET: begin
            count_q <= count_inc;
            if (count_q == RST_LAST) begin
              trig_rst <= 1'b0;
            end
            if (count_q == SETTLE_LAST) begin
              capture_en <= ch_en_q;
              count_q    <= '0;
              state_q    <= ST_PRE_TRIG;
            end
          end
          ST_PRE_TRIG: begin
            if (count_q == pre_q) begin
              count_q <= '0;
              state_q <= ST_ARMED;
            end else if (sample_valid) begin
              count_q <= count_inc;
            end
          end
          ST_ARMED: begin
            if (force_trig || match_fire || auto_fire) begin
              triggered <= 1'b1;
              count_q   <= '0;
              state_q   <= ST_POST_TRIG;
            end else begin
`ifdef LOGIC_TRIG_AUTO_EN
              count_q <= count_inc;
`else
              count_q <= count_q;
`endif
            end
          end
          ST_POST_TRIG: begin
            if (count_q == post_q) begin
              capture_en    <= '0;
              capture_flush <= ch_en_q;
              count_q       <= '0;
              state_q       <= ST_DONE;
            end else if (sample_valid) begin
              count_q <= count_inc;
            end
          end
          ST_DONE: begin
            if (download_done) begin
              triggered <= 1'b0;
              if (rearm) begin
                trig_rst <= 1'b1;
                count_q  <= '0;
                state_q  <= ST_RESET;
              end else begin
                state_q <= ST_CLEAR;
              end
            end
          end
          ST_CLEAR: begin
            if (!arm_req) begin
              state_q <= ST_IDLE;
            end
          end
          default: begin
            state_q <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_logic_trigger_sequencer.sv
// Directed self-checking bench for logic_trigger_sequencer (default build,
// LOGIC_TRIG_AUTO_EN undefined).
module tb_logic_trigger_sequencer;
  import logic_trig_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        arm_req;
  logic        mode_continuous;
  logic        force_trig;
  logic [1:0]  ch_en;
  logic [31:0] pre_depth;
  logic [31:0] post_depth;
  logic [31:0] trig_mask;
  logic [31:0] trig_value;
  logic        trig_edge;
  logic        sample_valid;
  logic [31:0] sample_data;
  logic        download_done;
`ifdef LOGIC_TRIG_AUTO_EN
  logic [31:0] auto_timeout;
`endif
  logic        trig_rst;
  logic [1:0]  capture_en;
  logic [1:0]  capture_flush;
  logic        triggered;
  logic        aborted;
  logic [2:0]  state;

  int checks = 0;
  int errors = 0;

  logic_trigger_sequencer dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .arm_req        (arm_req),
    .mode_continuous(mode_continuous),
    .force_trig     (force_trig),
    .ch_en          (ch_en),
    .pre_depth      (pre_depth),
    .post_depth     (post_depth),
    .trig_mask      (trig_mask),
    .trig_value     (trig_value),
    .trig_edge      (trig_edge),
    .sample_valid   (sample_valid),
    .sample_data    (sample_data),
    .download_done  (download_done),
`ifdef LOGIC_TRIG_AUTO_EN
    .auto_timeout   (auto_timeout),
`endif
    .trig_rst       (trig_rst),
    .capture_en     (capture_en),
    .capture_flush  (capture_flush),
    .triggered      (triggered),
    .aborted        (aborted),
    .state          (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cfg(input logic [1:0] ch, input int pre, input int post,
                         input logic [31:0] mask, input logic [31:0] value, input logic edg);
    ch_en      = ch;
    pre_depth  = pre;
    post_depth = post;
    trig_mask  = mask;
    trig_value = value;
    trig_edge  = edg;
  endtask

  // From RESET entry: 64 cycles to PRE_TRIG, then one more with pre_depth 0.
  task automatic wait_armed_pre0();
    repeat (64) tick();
    tick();
  endtask

  task automatic finish_capture();
    for (int i = 0; i < 64 && state !== ST_DONE; i++) begin
      sample_valid = 1'b1;
      tick();
    end
    sample_valid  = 1'b0;
    download_done = 1'b1;
    tick();
    download_done = 1'b0;
    arm_req       = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    checks++; if (state !== ST_IDLE) begin errors++; $display("[TB] FAIL reset_state got=%0d exp=%0d", state, ST_IDLE); end
    checks++; if ({trig_rst, capture_en, capture_flush, triggered, aborted} !== 7'd0) begin errors++; $display("[TB] FAIL reset_outputs got=%b exp=0000000", {trig_rst, capture_en, capture_flush, triggered, aborted}); end
    rst_n = 1'b1;
    tick();
    checks++; if (state !== ST_IDLE) begin errors++; $display("[TB] FAIL idle_hold got=%0d exp=%0d", state, ST_IDLE); end
  endtask

  task automatic test_basic();
    int hi;
    int n;
    set_cfg(2'b11, DEFAULT_PRE_DEPTH, DEFAULT_POST_DEPTH, 32'h0, 32'h0, 1'b0);
    arm_req = 1'b1;
    tick();
    checks++; if (state !== ST_RESET || trig_rst !== 1'b1) begin errors++; $display("[TB] FAIL arm_enter got state=%0d trig_rst=%b exp state=1 trig_rst=1", state, trig_rst); end
    hi = 0;
    while (trig_rst === 1'b1 && hi < 200) begin hi++; tick(); end
    checks++; if (hi !== 32) begin errors++; $display("[TB] FAIL trig_rst_len got=%0d exp=32", hi); end
    n = hi;
    while (capture_en === 2'b00 && n < 200) begin n++; tick(); end
    checks++; if (n !== 64 || state !== ST_PRE_TRIG || capture_en !== 2'b11) begin errors++; $display("[TB] FAIL capture_en_rise got cycles=%0d state=%0d en=%b exp 64/2/11", n, state, capture_en); end
    for (int i = 0; i < 4; i++) begin
      sample_valid = 1'b1; sample_data = 32'h100 + i; tick();
    end
    checks++; if (state !== ST_PRE_TRIG) begin errors++; $display("[TB] FAIL pre_hold got=%0d exp=2", state); end
    sample_valid = 1'b0;
    tick();
    checks++; if (state !== ST_ARMED) begin errors++; $display("[TB] FAIL pre_to_armed got=%0d exp=3", state); end
    tick(); tick();
    checks++; if (state !== ST_ARMED || triggered !== 1'b0) begin errors++; $display("[TB] FAIL armed_wait got state=%0d trig=%b exp 3/0", state, triggered); end
    sample_valid = 1'b1; sample_data = 32'hDEAD_BEEF;
    tick();
    checks++; if (state !== ST_POST_TRIG || triggered !== 1'b1) begin errors++; $display("[TB] FAIL mask0_fire got state=%0d trig=%b exp 4/1", state, triggered); end
    for (int i = 0; i < 8; i++) begin
      sample_valid = 1'b1; tick();
      sample_valid = 1'b0; tick();
    end
    checks++; if (state !== ST_DONE || capture_flush !== 2'b11 || capture_en !== 2'b00) begin errors++; $display("[TB] FAIL post_flush got state=%0d flush=%b en=%b exp 5/11/00", state, capture_flush, capture_en); end
    tick();
    checks++; if (capture_flush !== 2'b00 || state !== ST_DONE || triggered !== 1'b1) begin errors++; $display("[TB] FAIL flush_pulse got flush=%b state=%0d trig=%b exp 00/5/1", capture_flush, state, triggered); end
    download_done = 1'b1; tick(); download_done = 1'b0;
    checks++; if (state !== ST_CLEAR || triggered !== 1'b0) begin errors++; $display("[TB] FAIL done_to_clear got state=%0d trig=%b exp 6/0", state, triggered); end
    tick(); tick();
    checks++; if (state !== ST_CLEAR) begin errors++; $display("[TB] FAIL clear_hold got=%0d exp=6", state); end
    arm_req = 1'b0; tick();
    checks++; if (state !== ST_IDLE) begin errors++; $display("[TB] FAIL clear_to_idle got=%0d exp=0", state); end
  endtask

  task automatic test_edge_trigger();
    logic [31:0] stream [5];
    stream = '{32'h05, 32'h05, 32'h15, 32'h03, 32'h05};
    set_cfg(2'b11, 0, 2, 32'h0F, 32'h05, 1'b1);
    arm_req = 1'b1; tick();
    wait_armed_pre0();
    checks++; if (state !== ST_ARMED) begin errors++; $display("[TB] FAIL edge_armed got=%0d exp=3", state); end
    sample_valid = 1'b0; sample_data = 32'h05; tick();
    checks++; if (state !== ST_ARMED) begin errors++; $display("[TB] FAIL edge_invalid_ignored got=%0d exp=3", state); end
    for (int i = 0; i < 5; i++) begin
      sample_valid = 1'b1; sample_data = stream[i]; tick();
      if (i == 0) begin
        checks++; if (state !== ST_POST_TRIG || triggered !== 1'b1) begin errors++; $display("[TB] FAIL edge_first_fire got state=%0d trig=%b exp 4/1", state, triggered); end
      end
    end
    sample_valid = 1'b0;
    finish_capture();
    checks++; if (state !== ST_IDLE) begin errors++; $display("[TB] FAIL edge_return_idle got=%0d exp=0", state); end
    arm_req = 1'b1; tick();
    wait_armed_pre0();
    sample_valid = 1'b1; sample_data = 32'h03; tick();
    checks++; if (state !== ST_ARMED) begin errors++; $display("[TB] FAIL edge_gap_nofire got=%0d exp=3", state); end
    sample_data = 32'h05; tick();
    checks++; if (state !== ST_POST_TRIG) begin errors++; $display("[TB] FAIL edge_refire got=%0d exp=4", state); end
    sample_valid = 1'b0;
    finish_capture();
  endtask

  task automatic test_channel_mask();
    set_cfg(2'b10, 0, 1, 32'h0, 32'h0, 1'b0);
    arm_req = 1'b1; tick();
    ch_en = 2'b01;
    wait_armed_pre0();
    checks++; if (capture_en !== 2'b10) begin errors++; $display("[TB] FAIL chmask_en got=%b exp=10", capture_en); end
    sample_valid = 1'b1; tick();
    sample_valid = 1'b1; tick();
    sample_valid = 1'b0; tick();
    checks++; if (state !== ST_DONE || capture_flush !== 2'b10 || capture_en !== 2'b00) begin errors++; $display("[TB] FAIL chmask_flush got state=%0d flush=%b en=%b exp 5/10/00", state, capture_flush, capture_en); end
    finish_capture();
  endtask

  task automatic test_abort();
    set_cfg(2'b11, 4, 4, 32'h0, 32'h0, 1'b0);
    arm_req = 1'b1; tick();
    repeat (64) tick();
    checks++; if (state !== ST_PRE_TRIG || capture_en !== 2'b11) begin errors++; $display("[TB] FAIL abort_pre got state=%0d en=%b exp 2/11", state, capture_en); end
    arm_req = 1'b0; tick();
    checks++; if (state !== ST_IDLE || aborted !== 1'b1 || capture_en !== 2'b00 || capture_flush !== 2'b00 || trig_rst !== 1'b0) begin errors++; $display("[TB] FAIL abort_pulse got state=%0d ab=%b en=%b fl=%b rst=%b exp 0/1/00/00/0", state, aborted, capture_en, capture_flush, trig_rst); end
    tick();
    checks++; if (aborted !== 1'b0 || state !== ST_IDLE) begin errors++; $display("[TB] FAIL abort_one_cycle got ab=%b state=%0d exp 0/0", aborted, state); end
  endtask

  task automatic test_continuous();
    int flushes;
    flushes = 0;
    set_cfg(2'b11, 0, 1, 32'hFFFF_FFFF, 32'h1234_5678, 1'b0);
    mode_continuous = 1'b1;
    arm_req = 1'b1; tick();
    wait_armed_pre0();
    for (int k = 0; k < 3; k++) begin
      sample_valid = 1'b0; force_trig = 1'b1; tick(); force_trig = 1'b0;
      checks++; if (state !== ST_POST_TRIG || triggered !== 1'b1) begin errors++; $display("[TB] FAIL cont_force_%0d got state=%0d trig=%b exp 4/1", k, state, triggered); end
      sample_valid = 1'b1; tick();
      sample_valid = 1'b0; tick();
      if (capture_flush === 2'b11) flushes++;
      if (k == 2) mode_continuous = 1'b0;
      download_done = 1'b1; tick(); download_done = 1'b0;
      if (k < 2) begin
        checks++; if (state !== ST_RESET || triggered !== 1'b0 || trig_rst !== 1'b1) begin errors++; $display("[TB] FAIL cont_rearm_%0d got state=%0d trig=%b rst=%b exp 1/0/1", k, state, triggered, trig_rst); end
        wait_armed_pre0();
      end
    end
    checks++; if (flushes !== 3) begin errors++; $display("[TB] FAIL cont_captures got=%0d exp=3", flushes); end
    checks++; if (state !== ST_CLEAR) begin errors++; $display("[TB] FAIL cont_end_clear got=%0d exp=6", state); end
    arm_req = 1'b0; tick();
  endtask

  task automatic test_reset_mid_post();
    set_cfg(2'b11, 0, 8, 32'h0, 32'h0, 1'b0);
    arm_req = 1'b1; tick();
    wait_armed_pre0();
    force_trig = 1'b1; tick(); force_trig = 1'b0;
    sample_valid = 1'b1; tick(); tick();
    checks++; if (state !== ST_POST_TRIG || capture_en !== 2'b11) begin errors++; $display("[TB] FAIL midrst_pre got state=%0d en=%b exp 4/11", state, capture_en); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (state !== ST_IDLE || {trig_rst, capture_en, capture_flush, triggered, aborted} !== 7'd0) begin errors++; $display("[TB] FAIL midrst_async got state=%0d outs=%b exp 0/0000000", state, {trig_rst, capture_en, capture_flush, triggered, aborted}); end
    sample_valid = 1'b0; arm_req = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    checks++; if (state !== ST_IDLE) begin errors++; $display("[TB] FAIL midrst_idle got=%0d exp=0", state); end
  endtask

  initial begin
    rst_n = 1'b0; arm_req = 1'b0; mode_continuous = 1'b0; force_trig = 1'b0;
    sample_valid = 1'b0; sample_data = '0; download_done = 1'b0;
`ifdef LOGIC_TRIG_AUTO_EN
    auto_timeout = '0;
`endif
    set_cfg(2'b00, 0, 0, 32'h0, 32'h0, 1'b0);
    test_reset();
    test_basic();
    test_edge_trigger();
    test_channel_mask();
    test_abort();
    test_continuous();
    test_reset_mid_post();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
